mole_gen: RTL and testbench

- Upstream game core of the whack-a-mole display path.
- Picks a pseudo-random mole position and raises it for a timed window.
- Scores the player's button presses against the raised mole.
- Drives q[3:0], one bit per display digit, which the 7-segment multiplexer shows as 1 (mole up) or 0.

---
 rtl/mole_gen_pkg.sv | 22 ++
 rtl/mole_lfsr.sv | 24 ++
 rtl/mole_gen.sv | 164 ++++++++++++++++
 tb/tb_mole_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mole_gen_pkg.sv
// Shared definitions for the whack-a-mole game core: state encodings,
// LFSR tap mask and small helper functions.
package mole_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      SHOW = 2'd2
   } state_e;

   // x^8 + x^6 + x^5 + x^4 + 1 -> register bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [3:0] onehot4(input logic [1:0] pos);
      return 4'b0001 << pos;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR. A zero seed is replaced by 8'h01 so the
// register can never lock up in the all-zero state.
module mole_lfsr
   import mole_gen_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] lfsr
);

   localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

   // shift left, parity of the tapped bits enters at bit 0
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= INIT;
      end else begin
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/mole_gen.sv
// Whack-a-mole game core: raises a pseudo-random mole for a timed window and
// scores rising button edges against it. All outputs are registered.
// Optional macro MOLE_SPEEDUP_EN: each hit shortens the show window by
// SHOW_STEP down to SHOW_MIN; returning to IDLE restores SHOW_TICKS.
//
//   state | meaning
//   IDLE  | not playing, q=0000, busy=0
//   GAP   | between moles, q=0000, buttons ignored
//   SHOW  | mole raised, buttons scored, timer counts the window
module mole_gen
   import mole_gen_pkg::*;
#(
   parameter int unsigned SHOW_TICKS = 1000,
   parameter int unsigned GAP_TICKS  = 500,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5,
   parameter int unsigned SHOW_MIN   = 200,
   parameter int unsigned SHOW_STEP  = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] btn,
   output logic [3:0] q,
   output logic       hit,
   output logic       miss,
   output logic       busy
);

   localparam int unsigned   TW        = $clog2(max_u(SHOW_TICKS, GAP_TICKS) + 1);
   localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_TICKS);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_TICKS);
   localparam logic [TW-1:0] ONE       = TW'(1);

   // Both windows must be at least one tick, and the speed-up settings must
   // fit inside the base window.
   if (SHOW_TICKS < 1 || GAP_TICKS < 1 || SHOW_MIN > SHOW_TICKS || SHOW_STEP > SHOW_TICKS) begin : g_bad_cfg
      $error("mole_gen: illegal window parameters");
   end

   state_e        state;
   logic [TW-1:0] timer;
   logic [3:0]    btn_prev;
   logic [3:0]    rise;
   logic [1:0]    last_pos;
   logic [1:0]    pos;
   logic [7:0]    lfsr;
   logic [TW-1:0] show_load;
   logic          unused_lfsr_hi;

   mole_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   // only the low two bits pick the hole
   assign unused_lfsr_hi = ^lfsr[7:2];

   assign rise = btn & ~btn_prev;
   // never raise the same hole twice in a row
   assign pos  = (lfsr[1:0] == last_pos) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

`ifdef MOLE_SPEEDUP_EN
   localparam logic [TW-1:0] MIN_LOAD  = TW'(SHOW_MIN);
   localparam logic [TW-1:0] STEP_LOAD = TW'(SHOW_STEP);
   logic [TW-1:0] show_len;
   assign show_load = show_len;
`else
   assign show_load = SHOW_LOAD;
`endif

   // game FSM with registered outputs; stop overrides everything but rst
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         q        <= '0;
         hit      <= 1'b0;
         miss     <= 1'b0;
         busy     <= 1'b0;
         timer    <= '0;
         btn_prev <= '0;
         last_pos <= '0;
`ifdef MOLE_SPEEDUP_EN
         show_len <= SHOW_LOAD;
`endif
      end else begin
         btn_prev <= btn;
         hit      <= 1'b0;
         miss     <= 1'b0;
         if (stop) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
            timer <= '0;
`ifdef MOLE_SPEEDUP_EN
            show_len <= SHOW_LOAD;
`endif
         end else begin
            unique case (state)
               IDLE: begin
                  q <= '0;
                  if (start) begin
                     state <= GAP;
                     timer <= GAP_LOAD;
                     busy  <= 1'b1;
                  end
               end
               GAP: begin
                  if (tick) begin
                     if (timer == ONE) begin
                        state    <= SHOW;
                        timer    <= show_load;
                        q        <= onehot4(pos);
                        last_pos <= pos;
                     end else begin
                        timer <= timer - ONE;
                     end
                  end
               end
               SHOW: begin
                  if (rise == q) begin
                     hit   <= 1'b1;
                     q     <= '0;
                     state <= GAP;
                     timer <= GAP_LOAD;
`ifdef MOLE_SPEEDUP_EN
                     if (32'(show_len) >= SHOW_MIN + SHOW_STEP) begin
                        show_len <= show_len - STEP_LOAD;
                     end else begin
                        show_len <= MIN_LOAD;
                     end
`endif
                  end else if (rise != 4'b0000) begin
                     // wrong or multiple buttons: mole stays, window keeps running
                     miss <= 1'b1;
                     if (tick && timer != ONE) begin
                        timer <= timer - ONE;
                     end
                  end else if (tick) begin
                     if (timer == ONE) begin
                        miss  <= 1'b1;
                        q     <= '0;
                        state <= GAP;
                        timer <= GAP_LOAD;
                     end else begin
                        timer <= timer - ONE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  q     <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mole_gen.sv
// Scoreboard bench for mole_gen: every driven cycle pushes the reference
// model's expected outputs; a monitor pops and compares one entry per cycle.
module tb_mole_gen;

   localparam int SHOW  = 4;
   localparam int GAPN  = 2;
   localparam int STEPV = 1;
   localparam int MINV  = 2;
   localparam logic [7:0] SEED = 8'hA5;

   localparam int P_IDLE = 0;
   localparam int P_GAP  = 1;
   localparam int P_UP   = 2;

   typedef struct packed {
      logic [3:0] q;
      logic       hit;
      logic       miss;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b1;
   logic       start = 1'b1;
   logic       stop = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic [3:0] q;
   logic       hit;
   logic       miss;
   logic       busy;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;

   // reference model state
   logic [7:0] seq [255];
   int         m_phase, m_left, m_mole, m_last, m_win, m_idx;
   logic [3:0] m_prev, m_q;
   logic       m_hit, m_miss, m_busy;

   mole_gen #(
      .SHOW_TICKS (SHOW),
      .GAP_TICKS  (GAPN),
      .LFSR_SEED  (SEED),
      .SHOW_MIN   (MINV),
      .SHOW_STEP  (STEPV)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .start (start),
      .stop  (stop),
      .btn   (btn),
      .q     (q),
      .hit   (hit),
      .miss  (miss),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Game rules at the level of "which hole is up and how many ticks remain".
   function automatic void model(input logic r, input logic st, input logic sp,
                                 input logic tk, input logic [3:0] b);
      logic [3:0] rise;
      logic [3:0] up;
      int         pos;
      rise   = b & ~m_prev;
      up     = (m_mole < 0) ? 4'b0000 : 4'(4'b0001 << m_mole);
      m_hit  = 1'b0;
      m_miss = 1'b0;
      if (r) begin
         m_phase = P_IDLE; m_mole = -1; m_left = 0; m_prev = 4'b0000;
         m_idx = 0; m_last = 0; m_win = SHOW;
      end else begin
         if (sp) begin
            m_phase = P_IDLE; m_mole = -1; m_win = SHOW;
         end else if (m_phase == P_IDLE) begin
            if (st) begin m_phase = P_GAP; m_left = GAPN; end
         end else if (m_phase == P_GAP) begin
            if (tk) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  pos = int'(seq[m_idx]) % 4;
                  if (pos == m_last) pos = (pos + 1) % 4;
                  m_mole = pos; m_last = pos; m_phase = P_UP; m_left = m_win;
               end
            end
         end else begin
            if (rise == up) begin
               m_hit = 1'b1; m_mole = -1; m_phase = P_GAP; m_left = GAPN;
`ifdef MOLE_SPEEDUP_EN
               m_win = (m_win - STEPV < MINV) ? MINV : m_win - STEPV;
`endif
            end else if (rise != 4'b0000) begin
               m_miss = 1'b1;
               if (tk && m_left > 1) m_left = m_left - 1;
            end else if (tk) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_miss = 1'b1; m_mole = -1; m_phase = P_GAP; m_left = GAPN;
               end
            end
         end
         m_prev = b;
         m_idx  = (m_idx + 1) % 255;
      end
      m_busy = (m_phase != P_IDLE);
      m_q    = (m_mole < 0) ? 4'b0000 : 4'(4'b0001 << m_mole);
   endfunction

   task automatic step(input logic r, input logic st, input logic sp,
                       input logic tk, input logic [3:0] b);
      exp_t e;
      @(posedge clk);
      #2;
      rst = r; start = st; stop = sp; tick = tk; btn = b;
      model(r, st, sp, tk, b);
      e.q = m_q; e.hit = m_hit; e.miss = m_miss; e.busy = m_busy;
      exp_q.push_back(e);
   endtask

   task automatic wait_up(input string name);
      int n;
      n = 0;
      while (m_phase != P_UP && n < 40) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
         n++;
      end
      if (m_phase != P_UP) begin
         checks++;
         $display("FAIL %s: model never raised a mole within 40 cycles", name);
      end
   endtask

   function automatic logic [3:0] wrong_of(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

   // monitor: one expected entry per DUT cycle, sampled 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (q === e.q && hit === e.hit && miss === e.miss && busy === e.busy) begin
               passed++;
            end else begin
               $display("FAIL outputs cycle %0d: got q=%b hit=%b miss=%b busy=%b, want q=%b hit=%b miss=%b busy=%b",
                        cyc, q, hit, miss, busy, e.q, e.hit, e.miss, e.busy);
            end
            checks++;
            if (!(hit === 1'b1 && miss === 1'b1)) passed++;
            else $display("FAIL exclusive cycle %0d: hit=%b miss=%b both high", cyc, hit, miss);
         end
      end
   end

   initial begin
      logic [3:0] b;
      logic [3:0] held;
      int r;
      seq[0] = SEED;
      for (int i = 1; i < 255; i++)
         seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};

      // reset with start held, then idle
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

      // correct whack, then the next mole
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
      wait_up("whack");
      step(1'b0, 1'b0, 1'b0, 1'b1, m_q);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      wait_up("next_mole");

      // wrong hole, multi-button, then timeout
      step(1'b0, 1'b0, 1'b0, 1'b1, wrong_of(m_q));
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 1'b1, m_q | wrong_of(m_q));
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

      // correct press on the final tick, then hold it through the next round
      wait_up("collision");
      while (m_phase == P_UP && m_left > 1) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      held = m_q;
      step(1'b0, 1'b0, 1'b0, 1'b1, held);
      repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, held);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

      // stop with start mid-show
      wait_up("stop");
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

      // three hits in a row, then let the next mole time out
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         wait_up("speed");
         step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
         step(1'b0, 1'b0, 1'b0, 1'b1, m_q);
         step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      end
      wait_up("speed_timeout");
      repeat (8) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
      repeat (12) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

      // randomized play
      b = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 20) b = 4'b0000;
         else if (r < 35 && m_phase == P_UP) b = m_q;
         else if (r < 50) b = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), b);
      end

      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
